// File: rtl/onchip_memory_stream_master_pkg.sv
// Shared types and defaults for the on-chip memory stream master.
// Holds FSM state encodings, direction codes and default sizes.
package onchip_memory_stream_master_pkg;

   localparam int ADDR_W_DEF       = 12;
   localparam int DATA_W_DEF       = 32;
   localparam int READ_LATENCY_DEF = 1;
   localparam int FIFO_DEPTH_DEF   = 4;

   localparam logic DIR_WRITE = 1'b0;
   localparam logic DIR_READ  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/onchip_memory_stream_master_if.sv
// Command, Avalon-ST sink/source and Avalon-MM bundle.
// master: the stream master; slave: command/stream/memory side.
interface onchip_memory_stream_master_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;
   logic              done;
   logic              err;

   logic [DATA_W-1:0] snk_data;
   logic              snk_valid;
   logic              snk_ready;
   logic              snk_sop;
   logic              snk_eop;

   logic [DATA_W-1:0] src_data;
   logic              src_valid;
   logic              src_ready;
   logic              src_sop;
   logic              src_eop;

   logic [ADDR_W-1:0]   avm_address;
   logic                avm_chipselect;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_clken;
   logic [DATA_W-1:0]   avm_readdata;

   modport master (
      input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
      output cmd_ready, done, err,
      input  snk_data, snk_valid, snk_sop, snk_eop,
      output snk_ready,
      output src_data, src_valid, src_sop, src_eop,
      input  src_ready,
      output avm_address, avm_chipselect, avm_write,
      output avm_writedata, avm_byteenable, avm_clken,
      input  avm_readdata
   );

   modport slave (
      output cmd_valid, cmd_dir, cmd_addr, cmd_len,
      input  cmd_ready, done, err,
      output snk_data, snk_valid, snk_sop, snk_eop,
      input  snk_ready,
      input  src_data, src_valid, src_sop, src_eop,
      output src_ready,
      input  avm_address, avm_chipselect, avm_write,
      input  avm_writedata, avm_byteenable, avm_clken,
      output avm_readdata
   );
endinterface

// File: rtl/onchip_memory_stream_master_stream_fifo.sv
// Synchronous FIFO holding read-return words for the source.
// Ports: push/din in, pop/dout out (head), count/empty/full status.
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (!do_push && do_pop)
            count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/onchip_memory_stream_master.sv
// Avalon-MM master moving stream words to/from on-chip memory.
// Ports: clk, reset_n, bus (cmd, ST sink/source, avm_*, done/err).
module onchip_memory_stream_master
   import onchip_memory_stream_master_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = READ_LATENCY_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
   input logic clk,
   input logic reset_n,
   onchip_memory_stream_master_if.master m
);
   localparam int BE_W = DATA_W / 8;
   localparam int LW   = ADDR_W + 1;
   localparam int FCW  = $clog2(FIFO_DEPTH + 1);
   localparam int CW   = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
   localparam logic [BE_W-1:0] BE_ALL = '1;

   state_t state, state_n;

   logic [ADDR_W-1:0]       cur_addr;
   logic [LW-1:0]           remaining;
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           out_cnt;
   logic [READ_LATENCY-1:0] rd_pipe;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           credit;
   logic [FCW-1:0]          f_count;
   logic [DATA_W-1:0]       f_dout;
   logic f_empty, f_full;
   logic accept, beat, issue, rd_strobe, push, pop;

   assign m.cmd_ready = (state == S_IDLE);
   assign m.snk_ready = (state == S_WRITE);
   assign m.done      = (state == S_DONE);

   assign accept    = m.cmd_valid & m.cmd_ready;
   assign beat      = m.snk_valid & m.snk_ready;
   assign rd_strobe = m.avm_chipselect & ~m.avm_write;
   assign push      = rd_pipe[READ_LATENCY-1];
   assign pop       = m.src_valid & m.src_ready;

   // Reads on the bus or in the return pipe already own a FIFO slot.
   always_comb begin
      inflight = CW'(rd_strobe);
      for (int i = 0; i < READ_LATENCY; i++)
         inflight = inflight + CW'(rd_pipe[i]);
   end

   assign credit = CW'(f_count) + inflight;
   assign issue  = (state == S_READ) && (remaining != '0)
                && (credit < CW'(FIFO_DEPTH));

   assign m.src_valid = ~f_empty;
   assign m.src_data  = f_dout;
   assign m.src_sop   = ~f_empty & (out_cnt == '0);
   assign m.src_eop   = ~f_empty & (out_cnt == len_q - LW'(1));

   stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (m.avm_readdata),
      .pop     (pop),
      .dout    (f_dout),
      .count   (f_count),
      .empty   (f_empty),
      .full    (f_full)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (m.cmd_len == '0)
                  state_n = S_DONE;
               else if (m.cmd_dir == DIR_READ)
                  state_n = S_READ;
               else
                  state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            if (beat && remaining == LW'(1))
               state_n = S_DONE;
         end
         S_READ: begin
            if (issue && remaining == LW'(1))
               state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (inflight == '0 && f_empty)
               state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         cur_addr         <= '0;
         remaining        <= '0;
         len_q            <= '0;
         out_cnt          <= '0;
         rd_pipe          <= '0;
         m.err            <= 1'b0;
         m.avm_address    <= '0;
         m.avm_chipselect <= 1'b0;
         m.avm_write      <= 1'b0;
         m.avm_writedata  <= '0;
         m.avm_byteenable <= '0;
         m.avm_clken      <= 1'b0;
      end else begin
         state            <= state_n;
         m.avm_clken      <= 1'b1;
         m.err            <= 1'b0;
         m.avm_chipselect <= 1'b0;
         m.avm_write      <= 1'b0;
         m.avm_byteenable <= '0;
         rd_pipe[0]       <= rd_strobe;
         for (int i = 1; i < READ_LATENCY; i++)
            rd_pipe[i] <= rd_pipe[i-1];
         if (accept) begin
            cur_addr  <= m.cmd_addr;
            remaining <= m.cmd_len;
            len_q     <= m.cmd_len;
            out_cnt   <= '0;
         end
         if (beat) begin
            m.avm_chipselect <= 1'b1;
            m.avm_write      <= 1'b1;
            m.avm_address    <= cur_addr;
            m.avm_writedata  <= m.snk_data;
            m.avm_byteenable <= BE_ALL;
            cur_addr         <= cur_addr + ADDR_W'(1);
            remaining        <= remaining - LW'(1);
            // Framing is checked but the count alone ends the transfer.
            m.err <= m.snk_eop ^ (remaining == LW'(1));
         end
         if (issue) begin
            m.avm_chipselect <= 1'b1;
            m.avm_address    <= cur_addr;
            m.avm_byteenable <= BE_ALL;
            cur_addr         <= cur_addr + ADDR_W'(1);
            remaining        <= remaining - LW'(1);
         end
         if (pop)
            out_cnt <= out_cnt + LW'(1);
      end
   end
endmodule

// File: tb/tb_onchip_memory_stream_master.sv
// Scoreboard bench for onchip_memory_stream_master.
// Models the memory slave; checks writes, stream words, done/err.
module tb_onchip_memory_stream_master;
   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_exp_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          sop;
      logic          eop;
   } src_exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   onchip_memory_stream_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   onchip_memory_stream_master #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIFO_DEPTH(4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m       (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] ram     [4096];
   logic [DW-1:0] ref_mem [4096];

   always @(posedge clk) begin
      if (bus.avm_clken && bus.avm_chipselect) begin
         if (bus.avm_write)
            ram[bus.avm_address] <= bus.avm_writedata;
         else
            bus.avm_readdata <= ram[bus.avm_address];
      end
   end

   wr_exp_t  wq[$];
   src_exp_t sq[$];
   wr_exp_t  wcur;
   src_exp_t scur;
   int cyc = 0;
   int rd_issued = 0, popped = 0, max_out = 0;
   int rd_first = -1, rd_last = -1;
   int done_cnt = 0, err_cnt = 0, acc_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.avm_chipselect) acc_cnt++;
         if (bus.avm_chipselect && bus.avm_write) begin
            if (wq.size() == 0) begin
               check("wr_unexpected", 32'(wq.size()), 1);
            end else begin
               wcur = wq.pop_front();
               check("wr_addr", 32'(bus.avm_address), 32'(wcur.a));
               check("wr_data", bus.avm_writedata, wcur.d);
            end
         end
         if (bus.avm_chipselect && !bus.avm_write) begin
            rd_issued++;
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
         end
         if (bus.src_valid) begin
            if (sq.size() == 0) begin
               check("src_unexpected", 32'(sq.size()), 1);
            end else if (bus.src_ready) begin
               scur = sq.pop_front();
               popped++;
               check("src_data", bus.src_data, scur.d);
               check("src_sop", 32'(bus.src_sop), 32'(scur.sop));
               check("src_eop", 32'(bus.src_eop), 32'(scur.eop));
            end else begin
               check("stall_data", bus.src_data, sq[0].d);
            end
         end
         if (rd_issued - popped > max_out)
            max_out = rd_issued - popped;
         if (bus.done) done_cnt++;
         if (bus.err) err_cnt++;
      end
   end

   task automatic do_cmd(input logic dir,
                         input logic [AW-1:0] a,
                         input logic [AW:0] len);
      int n = 0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = dir;
      bus.cmd_addr  = a;
      bus.cmd_len   = len;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cmd_ready && n < 50);
      check("cmd_ready", 32'(bus.cmd_ready), 1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic eop);
      int n = 0;
      bus.snk_valid = 1'b1;
      bus.snk_data  = d;
      bus.snk_eop   = eop;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.snk_ready && n < 50);
      if (!bus.snk_ready)
         check("snk_ready_timeout", 32'(bus.snk_ready), 1);
      @(posedge clk); #1;
      bus.snk_valid = 1'b0;
      bus.snk_eop   = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 300);
      check({tag, "_done"}, 32'(bus.done), 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 0);
   endtask

   task automatic write_xfer(input logic [AW-1:0] a,
                             input int len,
                             input logic [DW-1:0] base,
                             input int eop_idx);
      logic [AW-1:0] ad;
      do_cmd(1'b0, a, (AW+1)'(len));
      for (int i = 0; i < len; i++) begin
         ad = a + AW'(i);
         wq.push_back('{a: ad, d: base + DW'(i)});
         ref_mem[ad] = base + DW'(i);
         send_beat(base + DW'(i), i == eop_idx);
      end
   endtask

   task automatic push_reads(input logic [AW-1:0] a, input int len);
      logic [AW-1:0] ad;
      for (int i = 0; i < len; i++) begin
         ad = a + AW'(i);
         sq.push_back('{d: ref_mem[ad], sop: i == 0,
                        eop: i == len - 1});
      end
   endtask

   task automatic read_xfer(input string tag,
                            input logic [AW-1:0] a,
                            input int len);
      push_reads(a, len);
      do_cmd(1'b1, a, (AW+1)'(len));
      wait_done(tag);
      check({tag, "_sq_empty"}, 32'(sq.size()), 0);
   endtask

   int acc_snap;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 32'h5A00_0000 | 32'(i);
         ref_mem[i] = 32'h5A00_0000 | 32'(i);
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.snk_valid = 1'b0;
      bus.snk_data  = '0;
      bus.snk_sop   = 1'b0;
      bus.snk_eop   = 1'b0;
      bus.src_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_cs", 32'(bus.avm_chipselect), 0);
      check("rst_addr", 32'(bus.avm_address), 0);
      check("rst_clken", 32'(bus.avm_clken), 0);
      check("rst_be", 32'(bus.avm_byteenable), 0);
      check("rst_flags", {29'd0, bus.done, bus.err, bus.src_valid}, 0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      reset_n = 1'b1;
      #1 check("clken_pre_edge", 32'(bus.avm_clken), 0);
      @(negedge clk);
      check("clken_post_edge", 32'(bus.avm_clken), 1);

      // Basic write then read back with sop/eop.
      err_cnt = 0;
      write_xfer(12'h010, 4, 32'hA0, 3);
      wait_done("wr4");
      check("wr4_err", 32'(err_cnt), 0);
      check("wr4_wq_empty", 32'(wq.size()), 0);

      rd_first = -1;
      read_xfer("rd4", 12'h010, 4);
      check("rd4_issue_span", 32'(rd_last - rd_first), 3);

      // Back-pressure on a longer read.
      write_xfer(12'h100, 8, 32'hB0, 7);
      wait_done("wr8");
      rd_issued = 0;
      popped = 0;
      max_out = 0;
      push_reads(12'h100, 8);
      do_cmd(1'b1, 12'h100, 13'd8);
      fork
         begin
            repeat (2) @(posedge clk);
            #1 bus.src_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 bus.src_ready = 1'b1;
         end
         wait_done("rd8");
      join
      check("rd8_sq_empty", 32'(sq.size()), 0);
      check("rd8_max_out_le4", 32'(max_out <= 4), 1);
      check("rd8_count", 32'(popped), 8);

      // Address wrap at top of memory.
      write_xfer(12'hFFE, 4, 32'hC0, 3);
      wait_done("wrap_wr");
      read_xfer("wrap_rd", 12'hFFE, 4);

      // Early eop: beat 2 and the eop-less last beat both flag.
      err_cnt = 0;
      write_xfer(12'h040, 3, 32'hD0, 1);
      wait_done("err_wr");
      check("err_count", 32'(err_cnt), 2);
      check("err_wq_empty", 32'(wq.size()), 0);
      read_xfer("err_rd", 12'h040, 3);

      // Zero length finishes without touching memory.
      acc_snap = acc_cnt;
      do_cmd(1'b0, 12'h020, 13'd0);
      wait_done("len0");
      check("len0_no_access", 32'(acc_cnt - acc_snap), 0);

      // Reset in the middle of a long read.
      push_reads(12'h000, 16);
      do_cmd(1'b1, 12'h000, 13'd16);
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_avm",
            {bus.avm_chipselect, bus.avm_write, bus.avm_clken,
             bus.avm_byteenable, 17'd0, bus.avm_address}, 0);
      check("mid_rst_flags", {29'd0, bus.done, bus.err, bus.src_valid}, 0);
      sq.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_rst_clken", 32'(bus.avm_clken), 1);
      read_xfer("post_rst_rd1", 12'h010, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t expected finish", $time);
      $fatal(1, "timeout");
   end
endmodule
